// File: rtl/mem_io_arbiter_pkg.sv
// mem_io_pkg
// Shared definitions for the data-memory / I/O arbiter slice:
//   IO_BASE_HI   upper 22 address bits that select the I/O region
//   state_e      arbiter FSM states
//   requester_e  identifies the CPU data port or the UART loader
//   is_io_region helper that decodes the I/O region from the upper address bits
package mem_io_pkg;

  localparam logic [21:0] IO_BASE_HI = 22'h3FFFFF;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    REQ_CPU = 1'b0,
    REQ_LD  = 1'b1
  } requester_e;

  function automatic logic is_io_region(input logic [21:0] addr_hi);
    return addr_hi == IO_BASE_HI;
  endfunction

endpackage

// File: rtl/mem_io_arbiter_io_decode.sv
// io_decode
// Combinational I/O region decode and pass-through for CPU accesses that
// target 0xFFFFFC00-0xFFFFFFFF. Such accesses never reach the RAM.
// Ports:
//   enable       1 = outputs live, 0 = all outputs forced to 0 (reset gating)
//   cpu_req      CPU access request
//   cpu_we       CPU write enable
//   cpu_addr_hi  cpu_addr[31:10]
//   cpu_wdata_lo cpu_wdata[15:0]
//   io_rdata     I/O read data (same cycle)
//   io_hit       raw decode: CPU request lies in the I/O region (ungated)
//   io_sel       I/O chip select
//   io_we        I/O write strobe
//   io_wdata     I/O write data
//   io_rword     I/O read data zero-extended to DATA_W, 0 when not selected
module io_decode
  import mem_io_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              enable,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [21:0]       cpu_addr_hi,
  input  logic [15:0]       cpu_wdata_lo,
  input  logic [15:0]       io_rdata,
  output logic              io_hit,
  output logic              io_sel,
  output logic              io_we,
  output logic [15:0]       io_wdata,
  output logic [DATA_W-1:0] io_rword
);

  // Region decode plus the gated I/O pass-through signals.
  always_comb begin
    io_hit   = cpu_req & is_io_region(cpu_addr_hi);
    io_sel   = enable & io_hit;
    io_we    = enable & io_hit & cpu_we;
    io_wdata = enable ? cpu_wdata_lo : 16'h0000;
    io_rword = (enable & io_hit) ? DATA_W'(io_rdata) : '0;
  end

endmodule

// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter
// Shares the single-port data RAM between the CPU data port and the UART
// program loader with round-robin arbitration, sequences the one-cycle
// synchronous RAM read, and routes CPU accesses in the I/O region straight
// to the I/O chip-select path.
// Ports:
//   clock, reset                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata        CPU request (byte address, bits [1:0] ignored)
//   cpu_rdata, cpu_ready         CPU read data and completion pulse
//   ld_req/we/addr/wdata         loader request (word address)
//   ld_rdata, ld_ready           loader read data and completion pulse
//   mem_en/we/addr/wdata         RAM control, zero when mem_en=0
//   mem_rdata                    RAM read data, one cycle after the read
//   io_sel/we/wdata, io_rdata    I/O chip-select path
// Only state, grant and pointer are registered; every output is
// combinational and forced to 0 while reset is low.
module mem_io_arbiter
  import mem_io_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              io_sel,
  output logic              io_we,
  output logic [15:0]       io_wdata,
  input  logic [15:0]       io_rdata
);

  state_e     state_q;
  requester_e grant_q;
  requester_e ptr_q;

  logic              io_hit;
  logic [DATA_W-1:0] io_rword;
  logic              cpu_mem_req;
  logic              grant_valid;
  requester_e        winner;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              cpu_done;
  logic              ld_done;
  logic              unused_cpu_addr;

  // The byte-offset bits never select anything.
  assign unused_cpu_addr = ^cpu_addr[1:0];

  io_decode #(
    .DATA_W(DATA_W)
  ) u_io_decode (
    .enable      (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr_hi (cpu_addr[31:10]),
    .cpu_wdata_lo(cpu_wdata[15:0]),
    .io_rdata    (io_rdata),
    .io_hit      (io_hit),
    .io_sel      (io_sel),
    .io_we       (io_we),
    .io_wdata    (io_wdata),
    .io_rword    (io_rword)
  );

  // Arbitration: only IDLE can grant. With both requesting, the pointer
  // holds the last-served requester, so the other one wins.
  always_comb begin
    cpu_mem_req = cpu_req & ~io_hit;
    grant_valid = (state_q == IDLE) & (cpu_mem_req | ld_req);
    if (cpu_mem_req & ld_req) begin
      winner = (ptr_q == REQ_CPU) ? REQ_LD : REQ_CPU;
    end else if (ld_req) begin
      winner = REQ_LD;
    end else begin
      winner = REQ_CPU;
    end
    if (winner == REQ_CPU) begin
      win_we    = cpu_we;
      win_addr  = cpu_addr[ADDR_W+1:2];
      win_wdata = cpu_wdata;
    end else begin
      win_we    = ld_we;
      win_addr  = ld_addr;
      win_wdata = ld_wdata;
    end
  end

  // Completion of a memory transaction: a write finishes on its grant
  // cycle, a read finishes in RD_WAIT for whoever holds the grant register.
  always_comb begin
    cpu_done = ((state_q == RD_WAIT) & (grant_q == REQ_CPU)) |
               (grant_valid & win_we & (winner == REQ_CPU));
    ld_done  = ((state_q == RD_WAIT) & (grant_q == REQ_LD)) |
               (grant_valid & win_we & (winner == REQ_LD));
  end

  // Output muxes; everything is held at 0 while reset is low.
  always_comb begin
    mem_en    = reset & grant_valid;
    mem_we    = reset & grant_valid & win_we;
    mem_addr  = (reset & grant_valid) ? win_addr : '0;
    mem_wdata = (reset & grant_valid) ? win_wdata : '0;

    cpu_ready = reset & (cpu_done | io_hit);
    ld_ready  = reset & ld_done;

    cpu_rdata = '0;
    if (reset & (state_q == RD_WAIT) & (grant_q == REQ_CPU)) begin
      cpu_rdata = mem_rdata;
    end else if (reset & io_hit) begin
      cpu_rdata = io_rword;
    end

    ld_rdata = '0;
    if (reset & (state_q == RD_WAIT) & (grant_q == REQ_LD)) begin
      ld_rdata = mem_rdata;
    end
  end

  // State, grant and pointer. A write grant updates the pointer at once;
  // a read grant parks in RD_WAIT and updates the pointer on completion.
  // Reset discards any in-flight read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= REQ_CPU;
      ptr_q   <= REQ_CPU;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            if (win_we) begin
              ptr_q <= winner;
            end else begin
              grant_q <= winner;
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          ptr_q   <= grant_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
